// File: rtl/player_pkg.sv
// player_pkg: transport state codes shared by the controller, sequencer and display decoder.
package player_pkg;
  localparam int STATE_W = 2;
  typedef enum logic [STATE_W-1:0] {
    ST_STOP  = 2'b00,
    ST_PLAY  = 2'b01,
    ST_PAUSE = 2'b10
  } state_e;
endpackage

// File: rtl/button_debounce.sv
// button_debounce: 2-flop synchroniser plus stability counter; one-cycle press pulse on each accepted rising level.
module button_debounce #(
  parameter int DEB_CYCLES = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic press
);
  localparam int CW = $clog2(DEB_CYCLES + 1);
  logic s1_q, s2_q, level_q, press_q;
  logic [CW-1:0] cnt_q;
  logic done;
  assign done = cnt_q == CW'(DEB_CYCLES - 1);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      s1_q    <= raw;
      s2_q    <= s1_q;
      press_q <= 1'b0;
      if (s2_q == level_q) cnt_q <= '0;
      else if (done) begin
        level_q <= s2_q;
        press_q <= s2_q;
        cnt_q   <= '0;
      end else cnt_q <= cnt_q + 1'b1;
    end
  end
  assign level = level_q;
  assign press = press_q;
endmodule

// File: rtl/player_ctrl_fsm.sv
// player_ctrl_fsm: debounced transport buttons driving play/pause/stop state, track index and restart pulse.
// Optional PLAYER_REPEAT_EN adds repeat_all: wrap to track 0 and keep playing after the last track.
module player_ctrl_fsm
  import player_pkg::*;
#(
  parameter int N_TRACKS   = 4,
  parameter int DEB_CYCLES = 8,
  localparam int TRACK_W   = (N_TRACKS > 1) ? $clog2(N_TRACKS) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               btn_play,
  input  logic               btn_stop,
  input  logic               btn_next,
  input  logic               btn_prev,
  input  logic               track_end,
`ifdef PLAYER_REPEAT_EN
  input  logic               repeat_all,
`endif
  output logic               playing,
  output logic [STATE_W-1:0] state,
  output logic [TRACK_W-1:0] track,
  output logic               restart
);
  localparam logic [TRACK_W-1:0] LAST = TRACK_W'(N_TRACKS - 1);
  logic [3:0] raw, prs;
  logic [TRACK_W-1:0] track_q, nxt, prv;
  state_e state_q;
  logic restart_q, playing_q, rep;
`ifdef PLAYER_REPEAT_EN
  assign rep = repeat_all;
`else
  assign rep = 1'b0;
`endif
  assign raw = {btn_prev, btn_next, btn_stop, btn_play};
  for (genvar i = 0; i < 4; i++) begin : g_deb
    button_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk(clk), .reset(reset), .raw(raw[i]), .level(), .press(prs[i])
    );
  end
  assign nxt = (track_q == LAST) ? '0 : track_q + 1'b1;
  assign prv = (track_q == '0) ? LAST : track_q - 1'b1;
  // Priority: illegal/stop > play > next > prev > track_end; one event per cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_STOP;
      track_q   <= '0;
      restart_q <= 1'b0;
      playing_q <= 1'b0;
    end else begin
      restart_q <= 1'b0;
      if (!(state_q inside {ST_STOP, ST_PLAY, ST_PAUSE}) || prs[1]) begin
        state_q   <= ST_STOP;
        playing_q <= 1'b0;
      end else if (prs[0]) begin
        state_q   <= (state_q == ST_PLAY) ? ST_PAUSE : ST_PLAY;
        playing_q <= state_q != ST_PLAY;
        restart_q <= state_q == ST_STOP;
      end else if (prs[2]) begin
        track_q   <= nxt;
        restart_q <= state_q == ST_PLAY;
      end else if (prs[3]) begin
        track_q   <= prv;
        restart_q <= state_q == ST_PLAY;
      end else if (track_end && state_q == ST_PLAY) begin
        track_q   <= nxt;
        restart_q <= (track_q != LAST) || rep;
        if (track_q == LAST && !rep) begin
          state_q   <= ST_STOP;
          playing_q <= 1'b0;
        end
      end
    end
  end
  assign state   = state_q;
  assign track   = track_q;
  assign restart = restart_q;
  assign playing = playing_q;
endmodule
